// File: rtl/entwurf_integrierter_schaltungen_hadner.sv
// PWM pulse-width analyzer: measures the high time of ui_in[7] in clock cycles and
// shows LOW / MID / HIGH as 'L' / '-' / 'H' on a 7-segment display with a valid flag.
//
// state    | meaning
// RES_NONE | no pulse measured since reset, display blank, valid low
// RES_LOW  | last pulse shorter than LOW_COUNTER_VALUE
// RES_MID  | last pulse within [LOW_COUNTER_VALUE, HIGH_COUNTER_VALUE]
// RES_HIGH | last pulse longer than HIGH_COUNTER_VALUE (includes saturated pulses)
module entwurf_integrierter_schaltungen_hadner #(
    parameter int MAX_COUNTER_VALUE  = 2000,
    parameter int HIGH_COUNTER_VALUE = 1900,
    parameter int LOW_COUNTER_VALUE  = 1100
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);
    localparam int CW = $clog2(MAX_COUNTER_VALUE + 1);
    localparam logic [CW-1:0] C_MAX  = CW'(MAX_COUNTER_VALUE);
    localparam logic [CW-1:0] C_HIGH = CW'(HIGH_COUNTER_VALUE);
    localparam logic [CW-1:0] C_LOW  = CW'(LOW_COUNTER_VALUE);

    localparam logic [6:0] SEG_BLANK = 7'h00;
    localparam logic [6:0] SEG_L     = 7'h38;
    localparam logic [6:0] SEG_DASH  = 7'h40;
    localparam logic [6:0] SEG_H     = 7'h76;

    typedef enum logic [1:0] {
        RES_NONE,
        RES_LOW,
        RES_MID,
        RES_HIGH
    } res_t;

    logic [2:0]    r_sync;
    logic          w_s;
    logic          w_s_d;
    logic          w_rise;
    logic          w_fall;
    logic [CW-1:0] r_count;
    logic [CW-1:0] w_count_nxt;
    res_t          r_res;
    res_t          w_res_nxt;
    logic [7:0]    r_out;
    logic [7:0]    w_out_nxt;
    logic          w_unused;

    assign w_unused = &{1'b0, ena, uio_in, ui_in[6:0]};

    // r_sync[1] is the synchronized input s, r_sync[2] its one-cycle delay s_d
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= 3'b000;
        end else begin
            r_sync <= {r_sync[1:0], ui_in[7]};
        end
    end

    assign w_s    = r_sync[1];
    assign w_s_d  = r_sync[2];
    assign w_rise = w_s & ~w_s_d;
    assign w_fall = ~w_s & w_s_d;

    always_comb begin
        w_count_nxt = r_count;
        if (w_rise) begin
            w_count_nxt = CW'(1);
        end else if (w_s && (r_count < C_MAX)) begin
            w_count_nxt = r_count + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else begin
            r_count <= w_count_nxt;
        end
    end

    // Result only moves on a fall; it never returns to RES_NONE outside reset,
    // which keeps the valid flag sticky.
    always_comb begin
        w_res_nxt = r_res;
        if (w_fall) begin
            if (r_count > C_HIGH) begin
                w_res_nxt = RES_HIGH;
            end else if (r_count < C_LOW) begin
                w_res_nxt = RES_LOW;
            end else begin
                w_res_nxt = RES_MID;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res <= RES_NONE;
        end else begin
            r_res <= w_res_nxt;
        end
    end

    always_comb begin
        w_out_nxt = {1'b0, SEG_BLANK};
        case (w_res_nxt)
            RES_LOW:  w_out_nxt = {1'b1, SEG_L};
            RES_MID:  w_out_nxt = {1'b1, SEG_DASH};
            RES_HIGH: w_out_nxt = {1'b1, SEG_H};
            default:  w_out_nxt = {1'b0, SEG_BLANK};
        endcase
    end

    // Display is registered alongside the result so uo_out comes straight from flops.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out <= 8'h00;
        end else begin
            r_out <= w_out_nxt;
        end
    end

    assign uo_out  = r_out;
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_entwurf_integrierter_schaltungen_hadner.sv
// Scoreboard bench for the PWM width analyzer: pulses are issued with their expected
// display code queued at the falling edge; a monitor pops and compares after each fall.
module tb_entwurf_integrierter_schaltungen_hadner;
    localparam int MAXV  = 2000;
    localparam int HIGHV = 1900;
    localparam int LOWV  = 1100;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic       pwm;
    logic [6:0] noise;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks = 0;
    int errors = 0;
    logic [7:0] exp_q[$];

    assign ui_in = {pwm, noise};

    entwurf_integrierter_schaltungen_hadner #(
        .MAX_COUNTER_VALUE (MAXV),
        .HIGH_COUNTER_VALUE(HIGHV),
        .LOW_COUNTER_VALUE (LOWV)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Unused inputs toggle randomly the whole run.
    always @(negedge clk) begin
        noise  = 7'($urandom);
        uio_in = 8'($urandom);
        ena    = 1'($urandom);
    end

    function automatic logic [7:0] expect_code(int width);
        int c;
        c = (width > MAXV) ? MAXV : width;
        if (c > HIGHV)     return 8'hF6;
        else if (c < LOWV) return 8'hB8;
        else               return 8'hC0;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Input is high for exactly n rising clock edges.
    task automatic pulse(int n, int gap);
        @(negedge clk);
        pwm = 1'b1;
        repeat (n) @(negedge clk);
        pwm = 1'b0;
        exp_q.push_back(expect_code(n));
        repeat (gap) @(negedge clk);
    endtask

    // Monitor: after each observed input fall, the display must show the queued
    // code within 4 clocks; outside those windows it must hold the last result.
    initial begin
        int         win;
        logic [7:0] pend;
        logic [7:0] cur_exp;
        logic       prev;
        win     = 0;
        pend    = 8'h00;
        cur_exp = 8'h00;
        prev    = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (!rst_n) begin
                exp_q.delete();
                cur_exp = 8'h00;
                win     = 0;
                prev    = pwm;
                check("reset_display", uo_out, 8'h00);
            end else begin
                if (prev && !pwm) begin
                    if (exp_q.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL scoreboard: fall seen with no expectation at %0t", $time);
                    end else begin
                        pend = exp_q.pop_front();
                        win  = 4;
                    end
                end
                prev = pwm;
                if (win > 0) begin
                    win--;
                    if (win == 0) begin
                        check("result", uo_out, pend);
                        cur_exp = pend;
                    end
                end else begin
                    check("hold", uo_out, cur_exp);
                end
                check("uio_const", {uio_oe, uio_out}, 16'h0000);
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int w;
        pwm   = 1'b0;
        rst_n = 1'b0;
        repeat (200) @(negedge clk);
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        pulse(1000, 19000);
        pulse(2000, 40);
        pulse(1500, 40);
        pulse(1100, 40);
        pulse(1098, 40);
        pulse(1900, 40);
        pulse(1902, 40);
        pulse(5000, 40);
        pulse(1000, 40);
        pulse(1, 10);
        pulse(2, 10);
        pulse(2100, 5);
        pulse(1, 5);

        for (int i = 0; i < 12; i++) begin
            w = $urandom_range(1, 2600);
            pulse(w, $urandom_range(5, 60));
        end

        pulse(1950, 20);
        // Reset 500 cycles into a pulse clears the display asynchronously.
        @(negedge clk);
        pwm = 1'b1;
        repeat (500) @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", uo_out, 8'h00);
        repeat (3) @(negedge clk);
        pwm = 1'b0;
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        pulse(1000, 30);

        // Reset released while the input is already high counts from the release.
        pulse(2000, 20);
        @(negedge clk);
        rst_n = 1'b0;
        pwm   = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (1100) @(negedge clk);
        pwm = 1'b0;
        exp_q.push_back(expect_code(1100));
        repeat (20) @(negedge clk);

        @(negedge clk);
        rst_n = 1'b0;
        pwm   = 1'b1;
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (1099) @(negedge clk);
        pwm = 1'b0;
        exp_q.push_back(expect_code(1099));
        repeat (20) @(negedge clk);

        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/entwurf_integrierter_schaltungen_hadner.md
# entwurf_integrierter_schaltungen_hadner

PWM pulse-width analyzer for a Tiny Tapeout tile. It measures the high time of an RC-servo-style PWM signal on `ui_in[7]` in clock cycles, with 1 µs per cycle at the intended 1 MHz clock. At the end of each pulse it classifies the width as LOW, MID or HIGH against two thresholds and shows the class on a 7-segment display driven from `uo_out`.

## Interface
Parameters:
- `MAX_COUNTER_VALUE`, default 2000: saturation value of the width counter.
- `HIGH_COUNTER_VALUE`, default 1900: a width strictly greater than this is HIGH.
- `LOW_COUNTER_VALUE`, default 1100: a width strictly less than this is LOW.
- Parameter constraint: LOW ≤ HIGH ≤ MAX. Counter width is the smallest n with 2^n > MAX.

Ports:
- `clk`  in  1  single system clock; all state on rising edge.
- `rst_n`  in  1  reset, asynchronous and active-low.
- `ena`  in  1  tile select; ignored.
- `ui_in`  in  8  bit 7 = PWM input; bits 6:0 unused.
- `uo_out`  out  8  [6:0] segments a..g (bit0=a … bit6=g), active high; [7] = valid flag.
- `uio_in`  in  8  unused.
- `uio_out`  out  8  constant 0.
- `uio_oe`  out  8  constant 0 (all inputs).

## Operation
- **Input synchronizer:** `ui_in[7]` passes through a 2-flop synchronizer, giving `s`. A third flop holds `s_d`.
- **Edge detection:** rise = `s & ~s_d`; fall = `~s & s_d`.
- **Width counter:**
  - On rise: loads 1.
  - While `s` = 1 with no rise: increments by 1, saturating at `MAX_COUNTER_VALUE` (never wraps).
  - While `s` = 0: holds its value.
- **Classification:** on fall, the counter value C is compared to the thresholds and a result register is loaded:
  - C > HIGH → HIGH, display 'H' = 0x76.
  - C < LOW → LOW, display 'L' = 0x38.
  - Otherwise → MID, display '-' = 0x40.
  - On the same fall, `uo_out[7]` is set to 1. It stays 1 until reset.
- **Result hold:** the result holds until the next fall. Rise, the high phase and saturation do not change the display.
- **Saturated pulse:** a pulse longer than MAX reports C = MAX. With default parameters this is HIGH.
- **Reset state (`rst_n` = 0):**
  - Synchronizer flops and `s_d` = 0.
  - Counter = 0.
  - Result = NONE: segments 0x00 (blank), `uo_out[7]` = 0.
- **Reset mid-pulse:** the partial measurement is discarded. After release, a pulse already high is seen as a rise, once `s` goes high following the release.
- **Pulse shorter than the synchronizer:** a pulse too short to be captured by the synchronizer produces no edge and no update. A captured pulse of C = 1 classifies LOW.
- **Unused inputs:** `ena`, `uio_in` and `ui_in[6:0]` have no effect.

## Timing
- **Measured width:** C equals the number of rising clock edges at which `s` = 1 during the pulse. For a clean input pulse of N cycles, C = N.
- **Synchronizer latency:** an input transition is visible on `s` 2 clocks after the first clock edge that samples it.
- **Update latency:** the result register and `uo_out` update on the clock edge after fall is detected. Total latency from the input falling edge to the display change is 3 clock cycles, ≤ 4 cycles worst case.
- **Outputs:** all outputs are registered or constant. No combinational path from `ui_in` to `uo_out`.
- **Reset release:** first counting is possible 2 clocks after `rst_n` rises and the input goes high.

## Test plan
- **Reset:** hold `rst_n`=0 for 200 cycles with `ui_in`=0, then release → `uo_out` = 0x00 throughout, `uio_oe` = `uio_out` = 0x00.
- **LOW pulse:** `ui_in[7]` high 1000 cycles, then low → within 4 cycles of the fall, `uo_out` = 0xB8 ('L' plus valid). It holds through a following 19000-cycle low phase.
- **HIGH pulse:** `ui_in[7]` high 2000 cycles (saturates at 2000), then low → within 4 cycles, `uo_out` = 0xF6 ('H' plus valid).
- **MID pulse:** high 1500 cycles → `uo_out` = 0xC0 ('-' plus valid). Boundary cases:
  - 1100 → MID; 1098 → LOW.
  - 1900 → MID; 1902 → HIGH.
  - Width ≥ 5000 → HIGH, with no counter wrap.
- **Display hold during next pulse:** after an 'H' result, start a 1000-cycle pulse → the display stays 'H' while high and changes to 'L' only after the fall.
- **Reset mid-pulse:** assert `rst_n` 500 cycles into a pulse → `uo_out` goes to 0x00 immediately (asynchronously). A subsequent full 1000-cycle pulse yields 0xB8.
